// File: rtl/alu_pkg.sv
// Shared opcode, writeback-select and state definitions for the ALU
// operation sequencer, plus opcode classification helpers.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_DIV  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b00101;
    localparam logic [4:0] OP_SHR  = 5'b00110;
    localparam logic [4:0] OP_SHRA = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_NEG  = 5'b01100;
    localparam logic [4:0] OP_NOT  = 5'b01101;

    localparam logic [1:0] WB_GPR = 2'd0;
    localparam logic [1:0] WB_LO  = 2'd1;
    localparam logic [1:0] WB_HI  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WB_LO,
        S_WB_HI
    } seq_state_t;

    // 01010 is a hole in the map; everything above 01101 is unused.
    function automatic logic is_legal_opcode(input logic [4:0] op);
        return (op <= OP_NOT) && (op != 5'b01010);
    endfunction

    function automatic logic is_two_word(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-drive and writeback bundle for the ALU operation sequencer.
// master: sequencer side. slave: requester / ALU / register-file side.
interface alu_op_sequencer_if;

    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_opcode;
    logic [31:0] req_ra;
    logic [31:0] req_rb;
    logic [3:0]  req_dest;

    logic [31:0] alu_ra;
    logic [31:0] alu_rb;
    logic [4:0]  alu_opcode;
    logic [63:0] alu_rz;

    logic        wb_valid;
    logic        wb_ready;
    logic [1:0]  wb_sel;
    logic [3:0]  wb_dest;
    logic [31:0] wb_data;

    logic        busy;
    logic        err_div0;
    logic        err_illegal;

    modport master (
        input  req_valid, req_opcode, req_ra, req_rb, req_dest,
        output req_ready,
        output alu_ra, alu_rb, alu_opcode,
        input  alu_rz,
        output wb_valid, wb_sel, wb_dest, wb_data,
        input  wb_ready,
        output busy, err_div0, err_illegal
    );

    modport slave (
        output req_valid, req_opcode, req_ra, req_rb, req_dest,
        input  req_ready,
        input  alu_ra, alu_rb, alu_opcode,
        output alu_rz,
        input  wb_valid, wb_sel, wb_dest, wb_data,
        output wb_ready,
        input  busy, err_div0, err_illegal
    );

endinterface

// File: rtl/alu_op_sequencer.sv
// Issues one op to an external combinational ALU, waits SETTLE_CYCLES,
// captures RZ and writes back one word (GPR) or two (LO then HI).
// Ports: clk, reset (sync, active-high), bus (alu_op_sequencer_if.master).
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    alu_op_sequencer_if.master     bus
);

    seq_state_t  state;
    logic [3:0]  cnt;
    logic [63:0] z;
    logic [3:0]  dest_q;
    logic        two_q;
    logic        div_q;
    logic        rdy_q;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    // Gated with reset so the request port is closed during the reset cycle itself.
    assign bus.req_ready = rdy_q & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            cnt             <= '0;
            z               <= '0;
            dest_q          <= '0;
            two_q           <= 1'b0;
            div_q           <= 1'b0;
            rdy_q           <= 1'b0;
            bus.alu_ra      <= '0;
            bus.alu_rb      <= '0;
            bus.alu_opcode  <= '0;
            bus.wb_valid    <= 1'b0;
            bus.wb_sel      <= WB_GPR;
            bus.wb_dest     <= '0;
            bus.wb_data     <= '0;
            bus.busy        <= 1'b0;
            bus.err_div0    <= 1'b0;
            bus.err_illegal <= 1'b0;
        end else begin
            bus.err_div0    <= 1'b0;
            bus.err_illegal <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    rdy_q <= 1'b1;
                    if (bus.req_valid && rdy_q) begin
                        if (!is_legal_opcode(bus.req_opcode)) begin
                            bus.err_illegal <= 1'b1;
                        end else if (bus.req_opcode == OP_DIV &&
                                     bus.req_rb == '0) begin
                            bus.err_div0 <= 1'b1;
                        end else begin
                            bus.alu_ra     <= bus.req_ra;
                            bus.alu_rb     <= bus.req_rb;
                            bus.alu_opcode <= bus.req_opcode;
                            dest_q         <= bus.req_dest;
                            two_q          <= is_two_word(bus.req_opcode);
                            div_q          <= (bus.req_opcode == OP_DIV);
                            cnt            <= '0;
                            rdy_q          <= 1'b0;
                            bus.busy       <= 1'b1;
                            state          <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == CNT_LAST) begin
                        z            <= bus.alu_rz;
                        bus.wb_valid <= 1'b1;
                        state        <= S_WB_LO;
                        if (two_q) begin
                            bus.wb_sel  <= WB_LO;
                            bus.wb_dest <= '0;
                            // Divider packs {quotient, remainder}; quotient goes first.
                            bus.wb_data <= div_q ? bus.alu_rz[63:32]
                                                 : bus.alu_rz[31:0];
                        end else begin
                            bus.wb_sel  <= WB_GPR;
                            bus.wb_dest <= dest_q;
                            bus.wb_data <= bus.alu_rz[31:0];
                        end
                    end
                end
                S_WB_LO: begin
                    if (bus.wb_ready) begin
                        if (two_q) begin
                            bus.wb_sel  <= WB_HI;
                            bus.wb_data <= div_q ? z[31:0] : z[63:32];
                            state       <= S_WB_HI;
                        end else begin
                            bus.wb_valid <= 1'b0;
                            bus.wb_sel   <= WB_GPR;
                            bus.wb_dest  <= '0;
                            bus.wb_data  <= '0;
                            bus.busy     <= 1'b0;
                            rdy_q        <= 1'b1;
                            state        <= S_IDLE;
                        end
                    end
                end
                S_WB_HI: begin
                    if (bus.wb_ready) begin
                        bus.wb_valid <= 1'b0;
                        bus.wb_sel   <= WB_GPR;
                        bus.wb_dest  <= '0;
                        bus.wb_data  <= '0;
                        bus.busy     <= 1'b0;
                        rdy_q        <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with a behavioural
// ALU attached to the alu_* / alu_rz side of the bus.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_op_sequencer_if bus ();

    alu_op_sequencer #(.SETTLE_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: div result packed as {quotient, remainder}.
    always_comb begin
        bus.alu_rz = '0;
        case (bus.alu_opcode)
            OP_ADD: bus.alu_rz = {32'd0, bus.alu_ra + bus.alu_rb};
            OP_SUB: bus.alu_rz = {32'd0, bus.alu_ra - bus.alu_rb};
            OP_MUL: bus.alu_rz = $signed(bus.alu_ra) * $signed(bus.alu_rb);
            OP_DIV: if (bus.alu_rb != 0)
                bus.alu_rz = {$signed(bus.alu_ra) / $signed(bus.alu_rb),
                              $signed(bus.alu_ra) % $signed(bus.alu_rb)};
            OP_AND: bus.alu_rz = {32'd0, bus.alu_ra & bus.alu_rb};
            OP_OR:  bus.alu_rz = {32'd0, bus.alu_ra | bus.alu_rb};
            default: bus.alu_rz = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] d);
        bus.req_valid  = 1'b1;
        bus.req_opcode = op;
        bus.req_ra     = a;
        bus.req_rb     = b;
        bus.req_dest   = d;
    endtask

    initial begin
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_opcode = '0;
        bus.req_ra     = '0;
        bus.req_rb     = '0;
        bus.req_dest   = '0;
        bus.wb_ready   = 1'b1;
        step();
        step();
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("rst_alu_ra", 64'(bus.alu_ra), 64'd0);
        chk("rst_wb_data", 64'(bus.wb_data), 64'd0);
        reset = 1'b0;
        step();
        chk("idle_req_ready", 64'(bus.req_ready), 64'd1);

        // add 5+7 -> GPR 3
        req(OP_ADD, 32'd5, 32'd7, 4'd3);
        step();
        bus.req_valid = 1'b0;
        chk("add_busy", 64'(bus.busy), 64'd1);
        chk("add_req_ready", 64'(bus.req_ready), 64'd0);
        chk("add_alu_ra", 64'(bus.alu_ra), 64'd5);
        chk("add_wbv_e1", 64'(bus.wb_valid), 64'd0);
        step();
        chk("add_wbv_e2", 64'(bus.wb_valid), 64'd0);
        step();
        chk("add_wbv", 64'(bus.wb_valid), 64'd1);
        chk("add_sel", 64'(bus.wb_sel), 64'(WB_GPR));
        chk("add_dest", 64'(bus.wb_dest), 64'd3);
        chk("add_data", 64'(bus.wb_data), 64'd12);
        chk("add_rdy_in_wb", 64'(bus.req_ready), 64'd0);
        step();
        chk("add_wbv_done", 64'(bus.wb_valid), 64'd0);
        chk("add_rdy_back", 64'(bus.req_ready), 64'd1);
        chk("add_busy_done", 64'(bus.busy), 64'd0);
        chk("idle_alu_ra_held", 64'(bus.alu_ra), 64'd5);

        // div 17/5 -> LO=3 (quotient), HI=2 (remainder)
        req(OP_DIV, 32'd17, 32'd5, 4'd1);
        step();
        bus.req_valid = 1'b0;
        step();
        step();
        chk("div_wbv1", 64'(bus.wb_valid), 64'd1);
        chk("div_sel1", 64'(bus.wb_sel), 64'(WB_LO));
        chk("div_dest1", 64'(bus.wb_dest), 64'd0);
        chk("div_data1", 64'(bus.wb_data), 64'd3);
        step();
        chk("div_wbv2", 64'(bus.wb_valid), 64'd1);
        chk("div_sel2", 64'(bus.wb_sel), 64'(WB_HI));
        chk("div_data2", 64'(bus.wb_data), 64'd2);
        step();
        chk("div_wbv_done", 64'(bus.wb_valid), 64'd0);
        chk("div_rdy_back", 64'(bus.req_ready), 64'd1);

        // mul -3*4 -> LO=FFFFFFF4, HI=FFFFFFFF
        req(OP_MUL, 32'hFFFF_FFFD, 32'd4, 4'd0);
        step();
        bus.req_valid = 1'b0;
        step();
        step();
        chk("mul_sel1", 64'(bus.wb_sel), 64'(WB_LO));
        chk("mul_lo", 64'(bus.wb_data), 64'hFFFF_FFF4);
        step();
        chk("mul_sel2", 64'(bus.wb_sel), 64'(WB_HI));
        chk("mul_hi", 64'(bus.wb_data), 64'hFFFF_FFFF);
        step();
        chk("mul_wbv_done", 64'(bus.wb_valid), 64'd0);

        // div by zero rejected
        req(OP_DIV, 32'd9, 32'd0, 4'd2);
        step();
        bus.req_valid = 1'b0;
        chk("d0_pulse", 64'(bus.err_div0), 64'd1);
        chk("d0_busy", 64'(bus.busy), 64'd0);
        chk("d0_wbv", 64'(bus.wb_valid), 64'd0);
        chk("d0_rdy", 64'(bus.req_ready), 64'd1);
        step();
        chk("d0_pulse_end", 64'(bus.err_div0), 64'd0);
        chk("d0_wbv_after", 64'(bus.wb_valid), 64'd0);

        // illegal opcode 01010
        req(5'b01010, 32'd1, 32'd1, 4'd2);
        step();
        bus.req_valid = 1'b0;
        chk("ill_pulse", 64'(bus.err_illegal), 64'd1);
        chk("ill_busy", 64'(bus.busy), 64'd0);
        step();
        chk("ill_pulse_end", 64'(bus.err_illegal), 64'd0);
        chk("ill_wbv", 64'(bus.wb_valid), 64'd0);

        // back-to-back illegal (11111) -> back-to-back pulses
        req(5'b11111, 32'd0, 32'd0, 4'd0);
        step();
        chk("ill2_p1", 64'(bus.err_illegal), 64'd1);
        step();
        bus.req_valid = 1'b0;
        chk("ill2_p2", 64'(bus.err_illegal), 64'd1);
        step();
        chk("ill2_end", 64'(bus.err_illegal), 64'd0);

        // sub 10-4 with writeback backpressure
        bus.wb_ready = 1'b0;
        req(OP_SUB, 32'd10, 32'd4, 4'd9);
        step();
        bus.req_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_wbv%0d", i), 64'(bus.wb_valid), 64'd1);
            chk($sformatf("bp_data%0d", i), 64'(bus.wb_data), 64'd6);
            chk($sformatf("bp_dest%0d", i), 64'(bus.wb_dest), 64'd9);
            if (i < 2) step();
        end
        bus.wb_ready = 1'b1;
        step();
        chk("bp_wbv_done", 64'(bus.wb_valid), 64'd0);
        step();

        // reset during ISSUE abandons the op
        req(OP_ADD, 32'd1, 32'd1, 4'd2);
        step();
        bus.req_valid = 1'b0;
        chk("mid_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        step();
        chk("mid_rdy", 64'(bus.req_ready), 64'd0);
        chk("mid_busy_rst", 64'(bus.busy), 64'd0);
        chk("mid_alu_ra", 64'(bus.alu_ra), 64'd0);
        chk("mid_alu_op", 64'(bus.alu_opcode), 64'd0);
        chk("mid_wbv", 64'(bus.wb_valid), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post_rst_wbv%0d", i), 64'(bus.wb_valid), 64'd0);
        end
        chk("post_rst_rdy", 64'(bus.req_ready), 64'd1);

        // new op after reset: 20+22 -> GPR 5
        req(OP_ADD, 32'd20, 32'd22, 4'd5);
        step();
        bus.req_valid = 1'b0;
        step();
        step();
        chk("post_wbv", 64'(bus.wb_valid), 64'd1);
        chk("post_data", 64'(bus.wb_data), 64'd42);
        chk("post_dest", 64'(bus.wb_dest), 64'd5);
        step();
        chk("post_done", 64'(bus.wb_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator/consumer on the far side of the combinational ALU interface (RA, RB, 5-bit opcode in; 64-bit RZ out).
- Accepts one ALU operation per request with a valid/ready handshake and drives registered operands and opcode to the ALU.
- Waits a fixed settle time, captures RZ into an internal 64-bit Z register, then writes back over a valid/ready write port.
- Writeback is one word for ordinary ops, or two words (LO then HI) for mul/div.

Parameters:
SETTLE_CYCLES, 2, cycles operands are held on the ALU before RZ is sampled (legal range 1..15)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept (high only in IDLE and not in reset)
req_opcode  in  5  ALU opcode
req_ra  in  32  operand A
req_rb  in  32  operand B / shift-rotate count / divisor
req_dest  in  4  destination GPR index
alu_ra  out  32  registered operand A to ALU
alu_rb  out  32  registered operand B to ALU
alu_opcode  out  5  registered opcode to ALU
alu_rz  in  64  ALU result
wb_valid  out  1  writeback word present
wb_ready  in  1  register file / HI-LO accepts word
wb_sel  out  2  0=GPR, 1=LO, 2=HI
wb_dest  out  4  GPR index; valid when wb_sel=0, otherwise 0
wb_data  out  32  writeback word
busy  out  1  high in any state other than IDLE
err_div0  out  1  one-cycle pulse: div with RB=0 rejected
err_illegal  out  1  one-cycle pulse: undefined opcode rejected

Behaviour:
- Opcodes: add 00000, sub 00001, mul 00010, div 00011, and 00100, or 00101, shr 00110, shra 00111, shl 01000, ror 01001, rol 01011, neg 01100, not 01101. All other codes (01010, 01110..11111) are illegal.
- Reset: state IDLE. All outputs 0, including req_ready, which stays 0 while reset is high. Z register and operand registers are cleared.
- Reset mid-operation: the operation is abandoned, and no writeback or error pulse occurs afterwards.
- States: IDLE, ISSUE, WB_LO (also used for single-word writeback), WB_HI.
- IDLE: req_ready=1. On req_valid&req_ready:
  - Illegal opcode: pulse err_illegal in the next cycle and stay in IDLE.
  - div with req_rb==0: pulse err_div0 in the next cycle and stay in IDLE.
  - Otherwise: latch opcode/ra/rb/dest into the alu_* registers, clear the settle counter, and go to ISSUE.
  - A rejected request still consumes the handshake.
- ISSUE: alu_* held stable. The counter increments each cycle. On the cycle where counter==SETTLE_CYCLES-1, Z<=alu_rz and the state moves to WB_LO. wb_valid therefore rises exactly SETTLE_CYCLES edges after the accepting edge.
- WB_LO, single-word ops: wb_sel=0, wb_dest=dest, wb_data=Z[31:0]. On wb_valid&wb_ready go to IDLE.
- WB_LO for mul: wb_sel=1, wb_data=Z[31:0]. For div: wb_sel=1, wb_data=Z[63:32] (quotient). On handshake go to WB_HI.
- WB_HI for mul: wb_sel=2, wb_data=Z[63:32]. For div: wb_sel=2, wb_data=Z[31:0] (remainder). On handshake go to IDLE.
- Backpressure: while wb_valid=1 and wb_ready=0, wb_sel/wb_dest/wb_data are held unchanged. wb_valid never drops without a handshake.
- alu_* retain their last values in IDLE; they change only on an accepting edge.
- No request is accepted in the same cycle as the final writeback handshake. req_ready rises the cycle after.
- Error pulses are exactly one cycle wide; back-to-back rejected requests give back-to-back pulses.

Decomposition:
- Shared package alu_pkg holds:
  - the 5-bit opcode constants above;
  - the wb_sel encodings WB_GPR=0, WB_LO=1, WB_HI=2;
  - the sequencer state enum;
  - a function is_legal_opcode and a function is_two_word (mul/div).
- The ALU is not instantiated inside this block; the top level or bench connects it.
- No sub-module is needed; the settle counter stays inline.

Test Plan:
- add, ra=5, rb=7, dest=3, SETTLE=2, wb_ready=1 -> wb_valid high 2 edges after accept; wb_sel=0, wb_dest=3, wb_data=12; req_ready returns 1 cycle after the handshake.
- div, ra=17, rb=5 -> word 1: wb_sel=1, wb_data=3. Word 2: wb_sel=2, wb_data=2. Exactly two handshakes.
- mul, ra=-3 (0xFFFFFFFD), rb=4 -> LO=0xFFFFFFF4, then HI=0xFFFFFFFF.
- div, rb=0 -> err_div0 high for exactly 1 cycle; wb_valid stays 0; busy stays 0. Opcode 01010 -> err_illegal single pulse, no writeback.
- sub, ra=10, rb=4, wb_ready low for 3 cycles -> wb_valid, wb_data=6 and wb_dest stable all 3 cycles; accepted on the 4th.
- Assert reset during ISSUE of an add -> next cycle all outputs 0 and state IDLE; no wb_valid afterwards. After reset drops, a new request is accepted normally.
